// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use a 32-step shift-add multiplier and DIV/DIVU a restoring divider.
// Both work on operand magnitudes; a final FIX cycle applies the sign correction
// and writes HI/LO. MTHI/MTLO writes are honoured only while the unit is idle.
module mult_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int W2 = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              is_div_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic              b_zero_q;
    // Multiplicand (MUL) or divisor (DIV) magnitude.
    logic [XLEN-1:0]   mag_q;
    // MUL: {partial product, multiplier}; DIV: {remainder, quotient}.
    logic [W2-1:0]     acc_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              busy_q;
    logic              done_q;
    logic              dbz_q;

    // Operand preparation at launch.
    logic              signed_op;
    logic              sign_a_d;
    logic              sign_b_d;
    logic [XLEN-1:0]   lat_a_d;
    logic [XLEN-1:0]   lat_b_d;

    // One iteration step and the sign fix-up result.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   rem_diff;
    logic              rem_ge;
    logic [W2-1:0]     acc_step_d;
    logic [W2-1:0]     prod_fix;
    logic [XLEN-1:0]   res_hi_d;
    logic [XLEN-1:0]   res_lo_d;

    // Launch-time operand magnitudes and signs (0x80000000 stays as unsigned 2^31).
    always_comb begin
        signed_op = ~op[0];
        sign_a_d  = signed_op & operand_a[XLEN-1];
        sign_b_d  = signed_op & operand_b[XLEN-1];
        if (sign_a_d) begin
            lat_a_d = -operand_a;
        end else begin
            lat_a_d = operand_a;
        end
        if (sign_b_d) begin
            lat_b_d = -operand_b;
        end else begin
            lat_b_d = operand_b;
        end
    end

    // Single shift-add or restoring-divide step on the shared accumulator.
    always_comb begin
        mul_sum    = {1'b0, acc_q[W2-1:XLEN]};
        rem_sh     = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
        rem_ge     = (rem_sh >= {1'b0, mag_q});
        rem_diff   = rem_sh[XLEN-1:0] - mag_q;
        acc_step_d = acc_q;
        if (is_div_q) begin
            if (rem_ge) begin
                acc_step_d = {rem_diff, acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_step_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc_q[0]) begin
                mul_sum = {1'b0, acc_q[W2-1:XLEN]} + {1'b0, mag_q};
            end else begin
                mul_sum = {1'b0, acc_q[W2-1:XLEN]};
            end
            // Right shift with the carry of the add entering the MSB.
            acc_step_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign correction of the magnitude result for signed operations.
    always_comb begin
        prod_fix = acc_q;
        res_hi_d = acc_q[W2-1:XLEN];
        res_lo_d = acc_q[XLEN-1:0];
        if (is_div_q) begin
            if (sign_a_q ^ sign_b_q) begin
                res_lo_d = -acc_q[XLEN-1:0];
            end else begin
                res_lo_d = acc_q[XLEN-1:0];
            end
            if (sign_a_q) begin
                res_hi_d = -acc_q[W2-1:XLEN];
            end else begin
                res_hi_d = acc_q[W2-1:XLEN];
            end
        end else begin
            if (sign_a_q ^ sign_b_q) begin
                prod_fix = -acc_q;
            end else begin
                prod_fix = acc_q;
            end
            res_hi_d = prod_fix[W2-1:XLEN];
            res_lo_d = prod_fix[XLEN-1:0];
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            mag_q    <= {XLEN{1'b0}};
            acc_q    <= {W2{1'b0}};
            hi_q     <= {XLEN{1'b0}};
            lo_q     <= {XLEN{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hi_we) begin
                        hi_q <= wdata;
                    end
                    if (lo_we) begin
                        lo_q <= wdata;
                    end
                    if (start) begin
                        is_div_q <= op[1];
                        sign_a_q <= sign_a_d;
                        sign_b_q <= sign_b_d;
                        b_zero_q <= (operand_b == {XLEN{1'b0}});
                        cnt_q    <= {CNT_W{1'b0}};
                        busy_q   <= 1'b1;
                        state_q  <= S_ITER;
                        if (op[1]) begin
                            mag_q <= lat_b_d;
                            acc_q <= {{XLEN{1'b0}}, lat_a_d};
                        end else begin
                            mag_q <= lat_a_d;
                            acc_q <= {{XLEN{1'b0}}, lat_b_d};
                        end
                    end
                end
                S_ITER: begin
                    acc_q <= acc_step_d;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    hi_q    <= res_hi_d;
                    lo_q    <= res_lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    dbz_q   <= is_div_q & b_zero_q;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
